// File: rtl/hamming7_pkg.sv
// Shared constants and Hamming(7,4) helper functions for the hamming7 link.
// Codeword bit k-1 carries position k: {d4,d3,d2,p3,d1,p2,p1}.
package hamming7_pkg;

   localparam int CODE_W = 7;
   localparam int DATA_W = 4;
   localparam int SYN_W  = 3;

   // Bit index of each 1-based codeword position.
   localparam int P1 = 0;
   localparam int P2 = 1;
   localparam int P3 = 2;
   localparam int P4 = 3;
   localparam int P5 = 4;
   localparam int P6 = 5;
   localparam int P7 = 6;

   // Syndrome {s3,s2,s1}: the 1-based position of a single flipped bit, 0 when clean.
   function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] code);
      logic [SYN_W-1:0] s;
      s[0] = code[P1] ^ code[P3] ^ code[P5] ^ code[P7];
      s[1] = code[P2] ^ code[P3] ^ code[P6] ^ code[P7];
      s[2] = code[P4] ^ code[P5] ^ code[P6] ^ code[P7];
      return s;
   endfunction

   // Flip the position named by syn (if any), then pull out {d4,d3,d2,d1}.
   function automatic logic [DATA_W-1:0] correct(input logic [CODE_W-1:0] code,
                                                 input logic [SYN_W-1:0]  syn);
      logic [CODE_W-1:0] mask;
      logic [CODE_W-1:0] fixed;
      mask = '0;
      if (syn != '0) begin
         mask[syn - 3'd1] = 1'b1;
      end
      fixed = code ^ mask;
      return {fixed[P7], fixed[P6], fixed[P5], fixed[P3]};
   endfunction

endpackage

// File: rtl/hamming7_syndrome.sv
// Combinational corrector between the S1 and S2 registers: applies the
// registered syndrome to the registered codeword and flags a correction.
module hamming7_syndrome
   import hamming7_pkg::*;
(
   input  logic [CODE_W-1:0] i_code,
   input  logic [SYN_W-1:0]  i_syn,
   output logic [DATA_W-1:0] o_data,
   output logic              o_err
);

   assign o_data = correct(i_code, i_syn);
   assign o_err  = (i_syn != '0);

endmodule

// File: rtl/hamming7_decoder.sv
// Hamming(7,4) receive decoder: 2-stage valid/ready pipeline with single-bit correction.
// Optional saturating corrected-error counter enabled by defining HAMMING7_ERR_CNT_EN.
module hamming7_decoder
   import hamming7_pkg::*;
`ifdef HAMMING7_ERR_CNT_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic [SYN_W-1:0]  out_syn
`ifdef HAMMING7_ERR_CNT_EN
   ,
   input  logic              cnt_clear,
   output logic [CNT_W-1:0]  err_count
`endif
);

   // Handshake: a word moves on a rising edge where valid && ready. The whole
   // pipe advances together when S2 is empty or the sink takes its word, so
   // in_ready never looks at in_valid and out_* hold while stalled.
   logic              w_adv;
   logic [SYN_W-1:0]  w_in_syn;
   logic [DATA_W-1:0] w_fix_data;
   logic              w_fix_err;

   logic              r_s1_valid;
   logic [CODE_W-1:0] r_s1_code;
   logic [SYN_W-1:0]  r_s1_syn;

   logic              r_s2_valid;
   logic [DATA_W-1:0] r_s2_data;
   logic              r_s2_err;
   logic [SYN_W-1:0]  r_s2_syn;

   assign w_adv    = !r_s2_valid || out_ready;
   assign in_ready = w_adv;
   assign w_in_syn = syndrome(in_code);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_code  <= '0;
         r_s1_syn   <= '0;
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_err   <= 1'b0;
         r_s2_syn   <= '0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         r_s2_valid <= r_s1_valid;
         if (in_valid) begin
            r_s1_code <= in_code;
            r_s1_syn  <= w_in_syn;
         end
         if (r_s1_valid) begin
            r_s2_data <= w_fix_data;
            r_s2_err  <= w_fix_err;
            r_s2_syn  <= r_s1_syn;
         end
      end
   end

   hamming7_syndrome u_syndrome (
      .i_code (r_s1_code),
      .i_syn  (r_s1_syn),
      .o_data (w_fix_data),
      .o_err  (w_fix_err)
   );

   assign out_valid = r_s2_valid;
   assign out_data  = r_s2_data;
   assign out_err   = r_s2_err;
   assign out_syn   = r_s2_syn;

`ifdef HAMMING7_ERR_CNT_EN
   // Counts corrected words as they leave; clear wins over a same-cycle increment.
   logic [CNT_W-1:0] r_err_count;
   logic             w_cnt_inc;

   assign w_cnt_inc = r_s2_valid && out_ready && r_s2_err && (r_err_count != '1);

   always_ff @(posedge clock) begin
      if (reset || cnt_clear) begin
         r_err_count <= '0;
      end else if (w_cnt_inc) begin
         r_err_count <= r_err_count + CNT_W'(1);
      end
   end

   assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_hamming7_decoder.sv
// Directed bench for hamming7_decoder: latency, correction, back-to-back sweep,
// backpressure, mid-stream reset and (with HAMMING7_ERR_CNT_EN) the error counter.
module tb_hamming7_decoder;

   localparam int TB_CNT_W = 2;
   localparam int CNT_MAX  = 3;

   logic       clock;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_code;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_err;
   logic [2:0] out_syn;
   logic       cnt_clear;
`ifdef HAMMING7_ERR_CNT_EN
   logic [TB_CNT_W-1:0] err_count;
`endif

   // Expected word layout: {data[7:4], err[3], syn[2:0]}.
   logic [7:0] exp_q[$];
   logic [7:0] in_exp;
   logic       last_acc;
   int         exp_cnt;
   int         checks;
   int         errors;

`ifdef HAMMING7_ERR_CNT_EN
   hamming7_decoder #(.CNT_W(TB_CNT_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_code   (in_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .out_syn   (out_syn),
      .cnt_clear (cnt_clear),
      .err_count (err_count)
   );
`else
   hamming7_decoder dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_code   (in_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .out_syn   (out_syn)
   );
`endif

   // Clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] enc(input logic [3:0] d);
      logic p1, p2, p3;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p3 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p3, d[0], p2, p1};
   endfunction

   // Driver
   task automatic offer(input logic [6:0] code, input logic [7:0] exp);
      in_valid = 1'b1;
      in_code  = code;
      in_exp   = exp;
   endtask

   // One clock: scoreboard both handshakes just before the edge, step to the
   // next falling edge, then compare the counter against the model.
   task automatic tick();
      logic [7:0] w;
      #1;
      last_acc = 1'b0;
      if (reset) begin
         exp_q.delete();
         exp_cnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
               w = exp_q.pop_front();
               check("out_word", {24'd0, out_data, out_err, out_syn}, {24'd0, w});
               if (w[3] && exp_cnt < CNT_MAX) exp_cnt++;
            end
         end
         if (cnt_clear) exp_cnt = 0;
         if (in_valid && in_ready) begin
            exp_q.push_back(in_exp);
            last_acc = 1'b1;
         end
      end
      @(posedge clock);
      @(negedge clock);
`ifdef HAMMING7_ERR_CNT_EN
      check("err_count", {30'd0, err_count}, exp_cnt);
`endif
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 12 && exp_q.size() > 0; i++) tick();
      check("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      logic [6:0] code;
      logic [6:0] one;
      logic [7:0] held;
      checks    = 0;
      errors    = 0;
      exp_cnt   = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_code   = '0;
      in_exp    = '0;
      out_ready = 1'b1;
      cnt_clear = 1'b0;
      one       = 7'd1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Reset state
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_data", {28'd0, out_data}, 0);
      check("rst_out_err", {31'd0, out_err}, 0);
      check("rst_out_syn", {29'd0, out_syn}, 0);
      check("rst_in_ready", {31'd0, in_ready}, 1);
`ifdef HAMMING7_ERR_CNT_EN
      check("rst_err_count", {30'd0, err_count}, 0);
`endif

      // Clean word and two-edge latency
      offer(7'h55, {4'hB, 1'b0, 3'd0});
      tick();
      in_valid = 1'b0;
      check("lat_s1_only", {31'd0, out_valid}, 0);
      tick();
      check("lat_out_valid", {31'd0, out_valid}, 1);
      drain();

      // Position 5 flipped
      offer(7'h45, {4'hB, 1'b1, 3'd5});
      tick();
      drain();
`ifdef HAMMING7_ERR_CNT_EN
      check("cnt_after_one", {30'd0, err_count}, 1);

      // Saturation, then clear colliding with an error handshake
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      check("cnt_cleared", {30'd0, err_count}, 0);
      offer(7'h45, {4'hB, 1'b1, 3'd5}); tick();
      offer(7'h1C, {4'h3, 1'b1, 3'd2}); tick();
      offer(7'h0C, {4'h9, 1'b1, 3'd7}); tick();
      offer(7'h54, {4'hB, 1'b1, 3'd1}); tick();
      offer(7'h60, {4'hC, 1'b1, 3'd1}); tick();
      drain();
      check("cnt_saturated", {30'd0, err_count}, CNT_MAX);
      offer(7'h45, {4'hB, 1'b1, 3'd5});
      tick();
      in_valid = 1'b0;
      tick();
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      check("cnt_clear_prio", {30'd0, err_count}, 0);
      drain();
`endif

      // Backpressure: 3 words offered while the sink stalls for 5 cycles
      out_ready = 1'b0;
      offer(7'h1C, {4'h3, 1'b1, 3'd2}); tick();
      offer(7'h61, {4'hC, 1'b0, 3'd0}); tick();
      offer(7'h0C, {4'h9, 1'b1, 3'd7});
      held = {out_data, out_err, out_syn};
      check("stall_first_word", {24'd0, held}, {24'd0, 4'h3, 1'b1, 3'd2});
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_in_ready", {31'd0, in_ready}, 0);
         check("stall_out_valid", {31'd0, out_valid}, 1);
         check("stall_out_stable", {24'd0, out_data, out_err, out_syn}, {24'd0, held});
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8 && !last_acc; i++) tick();
      check("stall_w3_taken", {31'd0, last_acc}, 1);
      drain();

      // Reset with two words in flight
      out_ready = 1'b0;
      offer(7'h0C, {4'h9, 1'b1, 3'd7}); tick();
      offer(7'h1C, {4'h3, 1'b1, 3'd2}); tick();
      in_valid = 1'b0;
      check("inflight_valid", {31'd0, out_valid}, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("post_rst_valid", {31'd0, out_valid}, 0);
      check("post_rst_in_ready", {31'd0, in_ready}, 1);
`ifdef HAMMING7_ERR_CNT_EN
      check("post_rst_count", {30'd0, err_count}, 0);
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("flushed_valid", {31'd0, out_valid}, 0);
         tick();
      end

      // 16 data values x flip positions 0..7, back-to-back
      for (int i = 0; i < 128; i++) begin
         code = enc(4'(i / 8));
         if (i % 8 != 0) code = code ^ (one << ((i % 8) - 1));
         if (i >= 2) check("sweep_no_gap", {31'd0, out_valid}, 1);
         offer(code, {4'(i / 8), (i % 8 != 0), 3'(i % 8)});
         tick();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
